ot_obuf_stream: RTL
===================

Name: ot_obuf_stream

Overview:
- Downstream stage of the quantization output gatherer.
- Accepts packed 64-bit words (8 int8 results, first-gathered byte in [63:56]) and buffers them in a small FIFO.
- Streams them out over a valid/ready master interface, framed by a programmed word count with last-word marking and a done pulse.
- The upstream gatherer has no backpressure, so overflow is detected and flagged, never stalled.

Parameters:
- DEPTH, 16, FIFO depth in 64-bit words; must be a power of 2, minimum 4.
- AW, 4, log2(DEPTH).
- LEN_W, 16, width of the frame word-count.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in64bits  input  64  packed word from the gatherer.
- in_valid  input  1  in64bits valid for this cycle (single-cycle pulses).
- cfg_start  input  1  start-frame pulse; honoured only in IDLE.
- cfg_len  input  LEN_W  number of words in the frame; sampled with cfg_start.
- m_tdata  output  64  output word.
- m_tvalid  output  1  m_tdata valid.
- m_tready  input  1  downstream accepts the word.
- m_tlast  output  1  current m_tdata is the last word of the frame.
- busy  output  1  high when the state is not IDLE.
- done  output  1  one-cycle pulse when the frame completes.
- overflow  output  1  sticky flag: an input word was dropped.
- fifo_count  output  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Clocking and reset:
  - All state is updated on posedge clk.
  - reset clears the pointers, fifo_count, remaining counter, state (to IDLE) and overflow.
  - All outputs are 0 during and after reset. FIFO memory is not reset.
- FIFO write:
  - A word is written when in_valid && (fifo_count < DEPTH).
  - When in_valid && fifo_count == DEPTH, the word is dropped and overflow is set.
  - Full is evaluated on the registered count. A write at full is dropped even if a read occurs in the same cycle.
  - Writes are accepted in every state, so prefill in IDLE is allowed.
- FIFO read (first-word-fall-through):
  - m_tdata = mem[rd_ptr] when m_tvalid, else 64'd0.
  - A word written in cycle N is visible on m_tdata in cycle N+1. There is no same-cycle bypass, including at empty.
  - m_tvalid = (state == RUN) && (fifo_count != 0).
  - A transfer occurs when m_tvalid && m_tready; rd_ptr then increments.
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready.
- Pointers and count:
  - Pointers are AW bits wide and wrap naturally.
  - fifo_count is +1 on write only, -1 on transfer only, unchanged when both or neither occur.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on cfg_start, remaining <= cfg_len. If cfg_len != 0, go to RUN; if cfg_len == 0, go straight to DONE.
  - RUN: each transfer decrements remaining. The transfer made with remaining == 1 goes to DONE.
  - DONE: done = 1 for exactly one cycle, then return to IDLE.
  - cfg_start is ignored in RUN and DONE.
- m_tlast = m_tvalid && (remaining == 1).
- Words left in the FIFO after a frame completes are kept for the next frame.
- overflow clears only on reset or on an accepted cfg_start. If a drop occurs in the same cycle as an accepted cfg_start, overflow is set (set wins).
- Reset mid-frame aborts the frame and discards all FIFO contents.
- in64bits is passed through unmodified; there is no byte reordering.

Test Plan:
- Basic frame: prefill 3 words A, B, C in IDLE, then cfg_start with cfg_len=3 and m_tready=1.
  - Required: m_tvalid rises the cycle after entering RUN; A, B, C are output in order.
  - Required: m_tlast is high only with C; done pulses 1 cycle after C is accepted; busy then falls.
- Backpressure: send 4 words with m_tready toggling 1,0,0,1.
  - Required: m_tdata/m_tlast hold during the stall; no word is lost or duplicated; fifo_count tracks exactly.
- Overflow: with no cfg_start, send DEPTH+2 words (16+2).
  - Required: fifo_count=16, overflow=1, and the last 2 words are dropped.
  - Then cfg_start with cfg_len=16: the first 16 words stream out and overflow clears.
- Simultaneous read and write: in RUN with fifo_count=1, m_tready=1 and in_valid=1 in the same cycle.
  - Required: count stays at 1 and the new word is output next.
  - Write at full during a read: the word is dropped and overflow=1.
- Zero-length frame and ignored start:
  - cfg_len=0: busy for 1 cycle, done pulses, no transfers.
  - cfg_start during RUN: no effect on remaining.
- Reset mid-frame: assert reset after 2 of 5 words are sent.
  - Required: all outputs are 0 and fifo_count=0.
  - A new frame of 2 words then completes normally.

Source files
------------

// File: rtl/ot_obuf_stream.sv
// ot_obuf_stream: FIFO-buffered 64-bit word streamer with framed valid/ready output and overflow flag
module ot_obuf_stream #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      in64bits,
  input  logic             in_valid,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [63:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [AW:0]      fifo_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [63:0]      mem_q [DEPTH];
  logic             full, wr, rd, start;
  always_comb begin
    full       = count_q == FULL_CNT;
    wr         = in_valid && !full;
    m_tvalid   = state_q == RUN && count_q != '0;
    rd         = m_tvalid && m_tready;
    start      = state_q == IDLE && cfg_start;
    m_tdata    = m_tvalid ? mem_q[rd_ptr_q] : '0;
    m_tlast    = m_tvalid && rem_q == LEN_W'(1);
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    overflow   = ovf_q;
    fifo_count = count_q;
    wr_ptr_d   = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = (wr && !rd) ? count_q + (AW+1)'(1) : (rd && !wr) ? count_q - (AW+1)'(1) : count_q;
    // a drop in the same cycle as an accepted start still leaves the flag set
    ovf_d      = (in_valid && full) || (ovf_q && !start);
    rem_d      = start ? cfg_len : rd ? rem_q - LEN_W'(1) : rem_q;
    state_d    = state_q == IDLE ? (cfg_start ? (cfg_len != '0 ? RUN : DONE) : IDLE)
               : state_q == RUN  ? ((rd && rem_q == LEN_W'(1)) ? DONE : RUN)
               : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= in64bits;
  end
endmodule
